mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Initiator side of the byte-wide data-memory interface (re/we/addr/di/data), as used by the on-chip RAM/IO responders.
- Accepts one byte, halfword or word load/store from the CPU memory stage.
- Serialises each request into 1, 2 or 4 little-endian byte beats on the memory port, then assembles and sign/zero-extends load data.
- Returns a single-cycle response to the pipeline.

Parameters:
- ADDR_W, 32, width of request and memory addresses.
- DATA_W, 32, width of request/response data. Fixed at 32; any other value is not supported.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  1  CPU request present.
- req_ready  output  1  unit can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
- req_signed  input  1  sign-extend load result; ignored for stores and word loads.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  DATA_W  store data; low bytes are used first.
- resp_valid  output  1  one-cycle completion pulse.
- resp_err  output  1  misaligned or reserved-size request; qualified by resp_valid.
- resp_rdata  output  DATA_W  extended load data; 0 for stores and errors.
- mem_re  output  1  memory read enable.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory byte address.
- mem_di  output  DATA_W  write data; {24'b0, byte}.
- mem_data  input  DATA_W  read data; combinational from mem_addr/mem_re; only [7:0] used.

Behaviour:
- Reset (rst=1 at a rising edge):
  - State goes to IDLE.
  - req_ready=1.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_re=0, mem_we=0, mem_addr=0, mem_di=0.
  - Beat counter and byte buffer cleared.
- Reset mid-transfer: abandons the request at that edge. No response is issued, and bytes already written stay written.
- States: IDLE, XFER, RESP.
- IDLE:
  - req_ready=1.
  - A request is accepted when req_valid & req_ready at an edge. At that edge all request fields are captured and beat is set to 0.
  - nbeats = 1/2/4 for size 00/01/10.
  - Error condition: size 11, or size 01 with addr[0]=1, or size 10 with addr[1:0]!=0. On error, go straight to RESP with err=1; no memory beats are issued.
  - Otherwise go to XFER.
- XFER: one beat per cycle, with req_ready=0.
  - mem_addr = captured addr + beat, wrapping modulo 2^ADDR_W.
  - Load beat: mem_re=1, mem_we=0. At the edge, mem_data[7:0] is stored in buffer byte [beat].
  - Store beat: mem_we=1, mem_re=0, mem_di = {24'b0, wdata[8*beat+7 : 8*beat]}.
  - mem_re and mem_we are never both 1. Both are 0 outside XFER.
  - When beat == nbeats-1, go to RESP; otherwise beat += 1.
- RESP: resp_valid=1 for exactly one cycle, req_ready=0, then return to IDLE.
  - Load rdata: byte → ext(buf[7:0]); half → ext(buf[15:0]); word → buf.
  - ext is sign-extension if signed=1, else zero-extension.
  - Store and error: rdata=0.
  - resp_err is held 0 except in an error RESP.
- Latency, counted from the accept edge to the cycle resp_valid is high:
  - byte: 2 cycles
  - half: 3 cycles
  - word: 5 cycles
  - error: 1 cycle
- Throughput: next accept is possible in the IDLE cycle after RESP. There is no back-to-back pipelining.
- No response backpressure: the consumer must take resp_valid when it pulses.
- req_valid while busy: ignored. The requester must hold it until req_ready.

Decomposition:
- Shared package:
  - Size encodings SZ_B, SZ_H, SZ_W.
  - FSM state encoding.
  - Function nbeats(size).
  - Function extend(data, size, signed).
- Sub-module load_extend: combinational buffer→resp_rdata extension. Reusable by a future cached LSU.
- The FSM stays in the top module.

Test Plan:
- Word store addr=0x10, wdata=0xA1B2C3D4, then word load addr=0x10:
  - Store: mem_we beats at 0x10..0x13 carry di 0xD4, 0xC3, 0xB2, 0xA1.
  - Load: resp_rdata=0xA1B2C3D4, resp_valid 5 cycles after accept.
- Byte 0x80 at addr 0x21:
  - Load with signed=1 → rdata 0xFFFFFF80.
  - Load with signed=0 → rdata 0x00000080.
  - Each takes exactly one mem_re beat.
- Half memory {0x22]=0x34, [0x23]=0x92}, signed load addr=0x22 → rdata 0xFFFF9234; unsigned → 0x00009234.
- Misaligned/reserved requests → resp_valid with resp_err=1 one cycle after accept, rdata=0, mem_re and mem_we stay 0 throughout. Cases:
  - half at 0x31
  - word at 0x32
  - size=11
- Word store to addr 0xFFFFFFFE-aligned case: use word at 0xFFFFFFFC → beats at 0xFFFFFFFC..0xFFFFFFFF.
- Byte store at 0xFFFFFFFF then byte load at 0x00000000 → confirms wrap arithmetic and no spill.
- Reset and busy handling:
  - Assert rst during beat 2 of a word store → next cycle state IDLE, req_ready=1, mem_we=0, no resp_valid.
  - req_valid held during XFER is not accepted until IDLE.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings and helpers for the byte-serial memory access unit.
package mem_access_unit_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic [2:0] nbeats(input logic [1:0] size);
    case (size)
      SZ_H:    nbeats = 3'd2;
      SZ_W:    nbeats = 3'd4;
      default: nbeats = 3'd1;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] data, input logic [1:0] size,
                                         input logic sgn);
    case (size)
      SZ_B:    extend = {{24{sgn & data[7]}}, data[7:0]};
      SZ_H:    extend = {{16{sgn & data[15]}}, data[15:0]};
      default: extend = data;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Combinational sign/zero extension of an assembled little-endian load buffer.
// Zero latency, no flow control.
module load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] i_buf,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  output logic [31:0] o_data
);

  assign o_data = extend(i_buf, i_size, i_signed);

endmodule

// File: rtl/mem_access_unit.sv
// Serialises one CPU load/store into 1/2/4 byte beats; response 2/3/5 cycles after accept (1 on error).
// Single outstanding request; req_ready only in IDLE, no response backpressure.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_di,
  input  logic [DATA_W-1:0] mem_data
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic              r_we;
  logic              r_signed;
  logic [DATA_W-1:0] r_wdata;
  logic              r_err;
  logic [1:0]        r_beat;
  logic [31:0]       r_buf;

  logic              w_accept;
  logic              w_req_err;
  logic              w_last;
  logic [ADDR_W-1:0] w_beat_addr;
  logic [7:0]        w_wbyte;
  logic [31:0]       w_ext;
  logic              w_unused_hi;

  // Only the low byte lane of the memory port carries data.
  assign w_unused_hi = ^mem_data[DATA_W-1:8];

  assign w_accept    = (r_state == ST_IDLE) && req_valid;
  assign w_req_err   = (req_size == 2'b11)
                     | ((req_size == SZ_H) & req_addr[0])
                     | ((req_size == SZ_W) & (req_addr[1:0] != 2'b00));
  assign w_last      = ({1'b0, r_beat} == (nbeats(r_size) - 3'd1));
  assign w_beat_addr = r_addr + {{(ADDR_W-2){1'b0}}, r_beat};
  assign w_wbyte     = r_wdata[{r_beat, 3'b000} +: 8];

  load_extend u_load_extend (
    .i_buf    (r_buf),
    .i_size   (r_size),
    .i_signed (r_signed),
    .o_data   (w_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_di      = '0;
    resp_valid  = 1'b0;
    resp_err    = 1'b0;
    resp_rdata  = '0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = w_req_err ? ST_RESP : ST_XFER;
      end
      ST_XFER: begin
        mem_re   = ~r_we;
        mem_we   = r_we;
        mem_addr = w_beat_addr;
        if (r_we) mem_di = {{(DATA_W-8){1'b0}}, w_wbyte};
        if (w_last) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        resp_valid  = 1'b1;
        resp_err    = r_err;
        if (!r_we && !r_err) resp_rdata = w_ext;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr   <= '0;
      r_size   <= SZ_B;
      r_we     <= 1'b0;
      r_signed <= 1'b0;
      r_wdata  <= '0;
      r_err    <= 1'b0;
      r_beat   <= 2'd0;
      r_buf    <= '0;
    end else if (w_accept) begin
      r_addr   <= req_addr;
      r_size   <= req_size;
      r_we     <= req_we;
      r_signed <= req_signed;
      r_wdata  <= req_wdata;
      r_err    <= w_req_err;
      r_beat   <= 2'd0;
      r_buf    <= '0;
    end else if (r_state == ST_XFER) begin
      if (!r_we) r_buf[{r_beat, 3'b000} +: 8] <= mem_data[7:0];
      if (!w_last) r_beat <= r_beat + 2'd1;
    end
  end

endmodule
